alu_serial_rx: RTL
==================

Name: alu_serial_rx

Overview:
Serial frame receiver on the ALU input side. It samples `sin` one bit per clock and deserializes 11-bit data and control frames. It assembles operands B and A, checks the CRC-4 and the opcode, and issues one decoded command per control frame. It feeds the ALU core and is the consumer of the stream the tester drives on `sin`.

Parameters:
DATA_FRAMES, 8, number of data frames required before a control frame (4 for B, then 4 for A)
FRAME_BITS, 11, total bits per frame including start and stop

Ports:
clk  input  1  system clock; `sin` is sampled on the rising edge
rst  input  1  asynchronous, active-high reset
sin  input  1  serial input; idles high; MSB of each frame first
cmd_valid  output  1  one-cycle pulse: a decoded command is on the outputs below
cmd_a  output  32  operand A (data frames 5..8; frame 5 = A[31:24])
cmd_b  output  32  operand B (data frames 1..4; frame 1 = B[31:24])
cmd_op  output  3  opcode from the control frame
err_data  output  1  wrong frame count or framing error (valid with cmd_valid)
err_crc  output  1  CRC mismatch (valid with cmd_valid)
err_op  output  1  opcode not in the valid set (valid with cmd_valid)

Behaviour:
- Reset: clk and a single asynchronous, active-high reset `rst`.
  - On `rst` all outputs go to 0.
  - FSM returns to IDLE; frame counter, shift register and bad-packet flag clear.
  - A reset mid-frame discards the partial frame and all collected data.
- Frame formats, MSB first:
  - Data frame: 0, 0, D[7:0], 1.
  - Control frame: 0, 1, 0, OP[2:0], CRC[3:0], 1.
- FSM states and transitions:
  - IDLE: waits for `sin`=0 (start bit), then goes to TYPE.
  - TYPE: latches the type bit (0 = data, 1 = control), then goes to PAYLOAD.
  - PAYLOAD: captures 8 bits via a 3-bit counter.
  - STOP: samples the stop bit, then returns to IDLE.
  - Back-to-back frames are allowed: a 0 sampled in the cycle after STOP starts a new frame.
- Stop bit = 0 is a framing error:
  - The frame is discarded and the sticky bad-packet flag is set.
  - The FSM returns to IDLE.
- Data frame with stop bit = 1:
  - Byte is shifted into a 64-bit {B,A} register.
  - Frame count increments, saturating at DATA_FRAMES+1.
  - A count exceeding DATA_FRAMES sets the bad-packet flag.
- Control frame with stop bit = 1:
  - cmd_valid pulses in the cycle after the stop bit is sampled (latency 1 clock).
  - err_data = (count != DATA_FRAMES) OR bad-packet flag.
  - err_crc = !err_data AND (received CRC != crc4_d68({B,A,1'b1,OP})).
  - err_op = !err_data AND !err_crc AND OP not in {AND=000, OR=001, ADD=100, SUB=101}.
  - At most one err_* bit is ever set; priority is DATA > CRC > OP.
  - cmd_a, cmd_b and cmd_op present the collected values and hold until the next cmd_valid.
  - Frame count and bad-packet flag clear for the next packet.
- Boundary conditions:
  - Long runs of 1s (e.g. 11'h7FF) are idle and are not frames.
  - A control frame with 0 data frames, or with fewer or more than 8, gives err_data.
  - A control frame whose own stop bit is 0 produces no command; the packet continues, flagged bad.

Decomposition:
- alu_pkg (shared):
  - operation_t encodings: AND_op=3'b000, OR_op=3'b001, ADD_op=3'b100, SUB_op=3'b101.
  - Frame type constants: DATA=0, CTL=1.
  - Function crc4_d68: polynomial x^4+x+1, init 0, 68-bit input.
  - Function is_valid_op.
- One sub-module: alu_frame_deser (IDLE/TYPE/PAYLOAD/STOP FSM).
  - Outputs a one-cycle frame_done, frame_type, payload[7:0] and frame_err.
  - alu_serial_rx owns the counting, assembly and checking.

Test Plan:
- 8 data frames of 8'h00, then a control frame with OP=000 and CRC=4'b1011 -> cmd_valid one clock after the control stop bit; cmd_a=0, cmd_b=0, cmd_op=000, all err_* = 0.
- Data bytes 11,22,33,44,55,66,77,88 (hex), then a control frame with OP=100 and correct CRC -> cmd_b=32'h11223344, cmd_a=32'h55667788, no errors.
- Same packet with the CRC field XOR 4'b0001 -> cmd_valid with err_crc=1 and err_data=err_op=0.
- 7 data frames, then a control frame, then 11 ones -> err_data=1 and no second cmd_valid; a following good packet decodes cleanly.
- Valid packet with OP=010 and correct CRC -> err_op=1 only; a 2nd data frame with stop bit 0 inside an otherwise good packet -> err_data=1.
- `rst` pulsed during the 5th data frame, then a full good packet -> all outputs 0 during reset and exactly one clean cmd_valid afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types, frame constants and check functions for the ALU serial receiver.
package alu_pkg;

    typedef enum logic [2:0] {
        AND_op = 3'b000,
        OR_op  = 3'b001,
        ADD_op = 3'b100,
        SUB_op = 3'b101
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        TYPE,
        PAYLOAD,
        STOP
    } deser_state_t;

    localparam logic DATA = 1'b0;
    localparam logic CTL  = 1'b1;

    // CRC-4, x^4+x+1, init 0, message consumed MSB first.
    function automatic logic [3:0] crc4_d68(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0};
            if (fb) c = c ^ 4'b0011;
        end
        return c;
    endfunction

    function automatic logic is_valid_op(input logic [2:0] op);
        return (op == AND_op) || (op == OR_op) || (op == ADD_op) || (op == SUB_op);
    endfunction

endpackage

// File: rtl/alu_frame_deser.sv
// Bit-level frame deserializer: start, type bit, 8 payload bits, stop.
// state   | meaning
// IDLE    | line idle, waiting for a 0 start bit
// TYPE    | sampling the type bit (0 = data, 1 = control)
// PAYLOAD | shifting in the 8 payload bits, MSB first
// STOP    | sampling the stop bit; frame_done strobes this cycle
module alu_frame_deser
    import alu_pkg::*;
#(
    parameter int FRAME_BITS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic       frame_done,
    output logic       frame_type,
    output logic [7:0] payload,
    output logic       frame_err
);

    localparam int          PAYLOAD_BITS = FRAME_BITS - 3;
    localparam logic [2:0]  BIT_LAST     = 3'(PAYLOAD_BITS - 1);

    deser_state_t state_q, state_d;
    logic         type_q, type_d;
    logic [7:0]   shift_q, shift_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            type_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // frame_done is combinational in STOP so the consumer registers its
    // result on the same edge that samples the stop bit.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sin) state_d = TYPE;
            end
            TYPE: begin
                type_d    = sin;
                bit_cnt_d = '0;
                state_d   = PAYLOAD;
            end
            PAYLOAD: begin
                shift_d   = {shift_q[6:0], sin};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == BIT_LAST) state_d = STOP;
            end
            STOP: begin
                frame_done = 1'b1;
                frame_err  = !sin;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign frame_type = type_q;
    assign payload    = shift_q;

endmodule

// File: rtl/alu_serial_rx.sv
// Packet layer of the ALU serial receiver: counts data frames, assembles {B,A},
// checks CRC and opcode, and issues one command per good control frame.
module alu_serial_rx
    import alu_pkg::*;
#(
    parameter int DATA_FRAMES = 8,
    parameter int FRAME_BITS  = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        cmd_valid,
    output logic [31:0] cmd_a,
    output logic [31:0] cmd_b,
    output logic [2:0]  cmd_op,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op
);

    localparam int               CNT_W    = $clog2(DATA_FRAMES + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_FRAMES);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_FRAMES + 1);

    logic       frame_done, frame_type, frame_err;
    logic [7:0] payload;

    alu_frame_deser #(.FRAME_BITS(FRAME_BITS)) u_deser (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .frame_done (frame_done),
        .frame_type (frame_type),
        .payload    (payload),
        .frame_err  (frame_err)
    );

    logic [CNT_W-1:0] count_q, count_d;
    logic             bad_q, bad_d;
    logic [63:0]      shreg_q, shreg_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [31:0]      cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;
    logic [2:0]       cmd_op_q, cmd_op_d;
    logic             err_data_q, err_data_d, err_crc_q, err_crc_d, err_op_q, err_op_d;

    logic [2:0] op_rx;
    logic [3:0] crc_rx, crc_calc;

    // Control payload is {0, OP[2:0], CRC[3:0]}; the CRC covers {B, A, type bit, OP}.
    assign op_rx    = payload[6:4];
    assign crc_rx   = payload[3:0];
    assign crc_calc = crc4_d68({shreg_q, CTL, op_rx});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            bad_q       <= 1'b0;
            shreg_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_a_q     <= '0;
            cmd_b_q     <= '0;
            cmd_op_q    <= '0;
            err_data_q  <= 1'b0;
            err_crc_q   <= 1'b0;
            err_op_q    <= 1'b0;
        end else begin
            count_q     <= count_d;
            bad_q       <= bad_d;
            shreg_q     <= shreg_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_a_q     <= cmd_a_d;
            cmd_b_q     <= cmd_b_d;
            cmd_op_q    <= cmd_op_d;
            err_data_q  <= err_data_d;
            err_crc_q   <= err_crc_d;
            err_op_q    <= err_op_d;
        end
    end

    always_comb begin
        count_d     = count_q;
        bad_d       = bad_q;
        shreg_d     = shreg_q;
        cmd_valid_d = 1'b0;
        cmd_a_d     = cmd_a_q;
        cmd_b_d     = cmd_b_q;
        cmd_op_d    = cmd_op_q;
        err_data_d  = err_data_q;
        err_crc_d   = err_crc_q;
        err_op_d    = err_op_q;
        if (frame_done) begin
            if (frame_err) begin
                bad_d = 1'b1;
            end else if (frame_type == DATA) begin
                shreg_d = {shreg_q[55:0], payload};
                if (count_q != CNT_SAT) count_d = count_q + CNT_W'(1);
                if (count_q >= CNT_FULL) bad_d = 1'b1;
            end else begin
                err_data_d  = (count_q != CNT_FULL) || bad_q;
                err_crc_d   = !err_data_d && (crc_rx != crc_calc);
                err_op_d    = !err_data_d && !err_crc_d && !is_valid_op(op_rx);
                cmd_valid_d = 1'b1;
                cmd_b_d     = shreg_q[63:32];
                cmd_a_d     = shreg_q[31:0];
                cmd_op_d    = op_rx;
                count_d     = '0;
                bad_d       = 1'b0;
            end
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_a     = cmd_a_q;
    assign cmd_b     = cmd_b_q;
    assign cmd_op    = cmd_op_q;
    assign err_data  = err_data_q;
    assign err_crc   = err_crc_q;
    assign err_op    = err_op_q;

endmodule
